// File: rtl/hdb3_encoder_if.sv
// Bit-stream interface of the HDB3 line encoder: NRZ input side and dual-rail output side.
//
// Handshake: there is no backpressure. The source presents din/ami_mode together with a
// one-cycle din_vld strobe; each cycle with din_vld=1 delivers exactly one bit, and
// back-to-back strobes are legal. The encoder answers every accepted bit with a one-cycle
// dout_vld pulse on the following cycle, when P/N carry the freshly emitted symbol.
interface hdb3_encoder_if;
    logic din;
    logic din_vld;
    logic ami_mode;
    logic P;
    logic N;
    logic dout_vld;

    // Bit source / line-driver side.
    modport master (
        output din, din_vld, ami_mode,
        input  P, N, dout_vld
    );

    // Encoder side.
    modport slave (
        input  din, din_vld, ami_mode,
        output P, N, dout_vld
    );
endinterface

// File: rtl/hdb3_encoder.sv
// HDB3 transmit encoder: AMI marking with 000V / B00V substitution of four-zero runs.
// A four-deep token pipeline delays every bit so that a B can be written back over the
// first zero of a run when the fourth zero arrives.
module hdb3_encoder #(
    parameter logic FIRST_POL = 1'b0  // polarity of the first mark: 0 = P rail, 1 = N rail
) (
    input logic           clk,
    input logic           rst_n,
    hdb3_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        TOK_ZERO = 2'b00,
        TOK_ONE  = 2'b01,
        TOK_V    = 2'b10,
        TOK_B    = 2'b11
    } tok_t;

    tok_t       sr0, sr1, sr2, sr3;  // sr0 newest, sr3 next to be emitted
    logic [1:0] zcnt;                // consecutive substitutable zeros accepted
    logic       par;                 // parity of ONE/B pulses since the last V
    logic       lastp;               // polarity of the last emitted pulse (1 = negative)

    tok_t       tok_in;
    logic [1:0] zcnt_nxt;
    logic       par_nxt;
    logic       b_ovr;
    logic       pulse;
    logic       pol;
    logic       lastp_nxt;

    // Classify the incoming bit into a token and decide on zero substitution.
    always_comb begin
        tok_in   = TOK_ZERO;
        zcnt_nxt = zcnt;
        par_nxt  = par;
        b_ovr    = 1'b0;
        if (bus.din) begin
            tok_in   = TOK_ONE;
            zcnt_nxt = 2'd0;
            par_nxt  = ~par;
        end else if (bus.ami_mode) begin
            zcnt_nxt = 2'd0;
        end else if (zcnt == 2'd3) begin
            // Fourth zero: V here; even parity also turns the run's first zero into B.
            tok_in   = TOK_V;
            zcnt_nxt = 2'd0;
            par_nxt  = 1'b0;
            b_ovr    = ~par;
        end else begin
            zcnt_nxt = zcnt + 2'd1;
        end
    end

    // Map the token leaving the pipeline onto a pulse and its polarity.
    always_comb begin
        pulse     = 1'b0;
        pol       = lastp;
        lastp_nxt = lastp;
        case (sr3)
            TOK_ONE, TOK_B: begin
                pulse     = 1'b1;
                pol       = ~lastp;
                lastp_nxt = ~lastp;
            end
            TOK_V: begin
                // A violation repeats the previous polarity on purpose.
                pulse = 1'b1;
                pol   = lastp;
            end
            default: begin
                pulse = 1'b0;
            end
        endcase
    end

    // Advance the pipeline and the output rails once per accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr0          <= TOK_ZERO;
            sr1          <= TOK_ZERO;
            sr2          <= TOK_ZERO;
            sr3          <= TOK_ZERO;
            zcnt         <= 2'd0;
            par          <= 1'b0;
            lastp        <= ~FIRST_POL;
            bus.P        <= 1'b0;
            bus.N        <= 1'b0;
            bus.dout_vld <= 1'b0;
        end else begin
            bus.dout_vld <= bus.din_vld;
            if (bus.din_vld) begin
                sr0   <= tok_in;
                sr1   <= sr0;
                sr2   <= sr1;
                sr3   <= b_ovr ? TOK_B : sr2;
                zcnt  <= zcnt_nxt;
                par   <= par_nxt;
                lastp <= lastp_nxt;
                bus.P <= pulse & ~pol;
                bus.N <= pulse & pol;
            end
        end
    end

endmodule

// File: tb/tb_hdb3_encoder.sv
// Directed bench for hdb3_encoder: hand-computed P/N sequences for mixed, all-zero,
// AMI, gapped-strobe and mid-stream-reset streams.
module tb_hdb3_encoder;

    localparam logic [1:0] Z  = 2'b00;  // {P,N} for no pulse
    localparam logic [1:0] PL = 2'b10;  // positive pulse
    localparam logic [1:0] MI = 2'b01;  // negative pulse

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   dv_cnt = 0;

    always #5 clk = ~clk;

    hdb3_encoder_if bus ();

    hdb3_encoder #(.FIRST_POL(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Count output strobes as seen at each rising edge.
    always @(posedge clk) begin
        if (bus.dout_vld === 1'b1) dv_cnt++;
    end

    // Rails must never both be active.
    always @(negedge clk) begin
        total++;
        assert (!(bus.P === 1'b1 && bus.N === 1'b1)) else begin
            bad++;
            $error("FAIL p_and_n observed=%b%b expected=not 11", bus.P, bus.N);
        end
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one bit, check the emitted symbol, then idle for gap cycles checking hold.
    task automatic send(input logic d, input logic ami, input logic [1:0] exp,
                        input int gap, input string tag);
        bus.din      = d;
        bus.ami_mode = ami;
        bus.din_vld  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.din_vld = 1'b0;
        bus.din     = 1'b0;
        chk({tag, " dout_vld"}, {1'b0, bus.dout_vld}, 2'b01);
        chk(tag, {bus.P, bus.N}, exp);
        repeat (gap) begin
            @(negedge clk);
            chk({tag, " hold"}, {bus.P, bus.N}, exp);
            chk({tag, " idle"}, {1'b0, bus.dout_vld}, 2'b00);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.din_vld = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Mixed stream; pads use ami_mode=1 so the trailing zeros stay plain zeros.
    logic       s1_din[16] = '{1,0,0,0,0,1,1,0,0,0,0,0, 0,0,0,0};
    logic [1:0] s1_exp[16] = '{Z,Z,Z,Z, PL,Z,Z,Z,PL,MI,PL,MI,Z,Z,MI,Z};
    // All zeros: B00V blocks with alternating polarity.
    logic [1:0] s2_exp[20] = '{Z,Z,Z,Z, PL,Z,Z,PL, MI,Z,Z,MI, PL,Z,Z,PL, MI,Z,Z,MI};
    // Plain AMI.
    logic       s3_din[12] = '{1,0,0,0,0,0,1,1, 0,0,0,0};
    logic [1:0] s3_exp[12] = '{Z,Z,Z,Z, PL,Z,Z,Z,Z,Z,MI,PL};
    // After mid-stream reset.
    logic       s5_din[6]  = '{1,1,0,0,0,0};
    logic [1:0] s5_exp[6]  = '{Z,Z,Z,Z,PL,MI};

    initial begin
        int base;
        rst_n        = 1'b0;
        bus.din      = 1'b0;
        bus.din_vld  = 1'b0;
        bus.ami_mode = 1'b0;
        #1;
        chk("reset pn", {bus.P, bus.N}, Z);
        chk("reset dout_vld", {1'b0, bus.dout_vld}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", {bus.P, bus.N}, Z);

        // Mixed stream, back-to-back strobes.
        for (int i = 0; i < 16; i++)
            send(s1_din[i], (i >= 12), s1_exp[i], 0, $sformatf("mixed[%0d]", i));

        // All zeros.
        do_reset();
        for (int i = 0; i < 20; i++)
            send(1'b0, 1'b0, s2_exp[i], 0, $sformatf("zeros[%0d]", i));

        // AMI only.
        do_reset();
        for (int i = 0; i < 12; i++)
            send(s3_din[i], 1'b1, s3_exp[i], 0, $sformatf("ami[%0d]", i));

        // Mixed stream with random gaps; outputs must hold and strobes must match.
        do_reset();
        @(negedge clk);
        base = dv_cnt;
        for (int i = 0; i < 16; i++)
            send(s1_din[i], (i >= 12), s1_exp[i], int'($urandom_range(0, 5)),
                 $sformatf("gap[%0d]", i));
        @(negedge clk);
        chk_int("gap strobe count", dv_cnt - base, 16);

        // Reset after 6 bits, then a short stream.
        do_reset();
        for (int i = 0; i < 6; i++)
            send(s1_din[i], 1'b0, s1_exp[i], 0, $sformatf("prerst[%0d]", i));
        rst_n = 1'b0;
        #1;
        chk("midreset pn", {bus.P, bus.N}, Z);
        chk("midreset dout_vld", {1'b0, bus.dout_vld}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            send(s5_din[i], 1'b0, s5_exp[i], 0, $sformatf("postrst[%0d]", i));

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
